// File: rtl/sync_cnt.sv
// Free-running synchronous counter built from T-type register bits.
// Width, modulus and count direction are fixed at elaboration.
module sync_cnt #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 32'd1 << WIDTH,
  parameter bit          DOWN    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out
);

  localparam int unsigned     STATES = 32'd1 << WIDTH;
  localparam bit              FULL   = (MODULUS == STATES);
  localparam logic [WIDTH-1:0] TERM  = WIDTH'(MODULUS - 32'd1);

  generate
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("sync_cnt: WIDTH must be in 1..16");
    end
    if (MODULUS < 2 || MODULUS > STATES) begin : g_bad_modulus
      $error("sync_cnt: MODULUS must be in 2..2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] toggle;
  logic             chain;
  logic             at_wrap;
  logic [WIDTH-1:0] wrap_val;

  // Toggle enables: AND chain over lower bits (ones counting up, zeros counting down).
  always_comb begin
    toggle = '0;
    chain  = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      toggle[i] = chain;
      chain     = chain & (DOWN ? ~out[i] : out[i]);
    end
  end

  // Truncated moduli replace the toggle with a load at the wrap point.
  always_comb begin
    if (DOWN) begin
      at_wrap  = !FULL && (out == '0);
      wrap_val = TERM;
    end else begin
      at_wrap  = !FULL && (out == TERM);
      wrap_val = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else if (at_wrap) begin
      out <= wrap_val;
    end else begin
      out <= out ^ toggle;
    end
  end

endmodule

// File: tb/tb_sync_cnt.sv
// Self-checking bench for sync_cnt: default up, modulus-10 up and down-counting instances
// compared every edge against a modular-arithmetic reference model.
module tb_sync_cnt;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] out_def;
  logic [3:0] out_m10;
  logic [3:0] out_dn;

  int compared   = 0;
  int mismatched = 0;
  int m_def = 0;
  int m_m10 = 0;
  int m_dn  = 0;

  always #5 clk = ~clk;

  sync_cnt u_def (.clk(clk), .rst(rst), .out(out_def));
  sync_cnt #(.WIDTH(4), .MODULUS(10)) u_m10 (.clk(clk), .rst(rst), .out(out_m10));
  sync_cnt #(.WIDTH(4), .DOWN(1'b1)) u_dn (.clk(clk), .rst(rst), .out(out_dn));

  function automatic int model_next(input int v, input int m, input bit down, input bit r);
    if (r) return 0;
    return down ? (v + m - 1) % m : (v + 1) % m;
  endfunction

  // Drive rst for the coming edge, then sample 1 ns after it.
  task automatic tick(input bit r);
    rst = r;
    @(posedge clk);
    #1;
    m_def = model_next(m_def, 16, 1'b0, r);
    m_m10 = model_next(m_m10, 10, 1'b0, r);
    m_dn  = model_next(m_dn, 16, 1'b1, r);
  endtask

  task automatic test_reset;
    for (int k = 0; k < 2; k++) begin
      tick(1'b1);
      compared++;
      if (out_def !== 4'd0 || out_m10 !== 4'd0 || out_dn !== 4'd0) begin
        mismatched++;
        $display("FAIL reset_hold edge %0d: def=%0d m10=%0d dn=%0d want 0", k, out_def, out_m10, out_dn);
      end
    end
    tick(1'b0);
    compared++;
    if (out_def !== 4'd1 || out_m10 !== 4'd1 || out_dn !== 4'd15) begin
      mismatched++;
      $display("FAIL reset_release: def=%0d m10=%0d dn=%0d want 1 1 15", out_def, out_m10, out_dn);
    end
  endtask

  task automatic test_up_sequence;
    tick(1'b1);
    for (int k = 1; k <= 17; k++) begin
      tick(1'b0);
      compared++;
      if (out_def !== 4'(k % 16)) begin
        mismatched++;
        $display("FAIL up_seq edge %0d: got %0d want %0d", k, out_def, k % 16);
      end
    end
  endtask

  task automatic test_down;
    tick(1'b1);
    compared++;
    if (out_dn !== 4'd0) begin
      mismatched++;
      $display("FAIL down_reset: got %0d want 0", out_dn);
    end
    for (int k = 1; k <= 16; k++) begin
      tick(1'b0);
      compared++;
      if (out_dn !== 4'((16 - k) % 16)) begin
        mismatched++;
        $display("FAIL down_seq edge %0d: got %0d want %0d", k, out_dn, (16 - k) % 16);
      end
    end
  endtask

  task automatic test_mid_reset;
    bit found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick(1'b0);
      if (m_def == 9) found = 1'b1;
    end
    compared++;
    if (!found || out_def !== 4'd9) begin
      mismatched++;
      $display("FAIL mid_reset_reach9: got %0d want 9 (found=%0d)", out_def, found);
    end
    tick(1'b1);
    compared++;
    if (out_def !== 4'd0 || out_m10 !== 4'd0 || out_dn !== 4'd0) begin
      mismatched++;
      $display("FAIL mid_reset_clear: def=%0d m10=%0d dn=%0d want 0", out_def, out_m10, out_dn);
    end
    tick(1'b0);
    compared++;
    if (out_def !== 4'd1) begin
      mismatched++;
      $display("FAIL mid_reset_resume: got %0d want 1", out_def);
    end
  endtask

  task automatic test_reset_held;
    for (int k = 0; k < 20; k++) begin
      tick(1'b1);
      compared++;
      if (out_def !== 4'd0 || out_m10 !== 4'd0 || out_dn !== 4'd0) begin
        mismatched++;
        $display("FAIL reset_held edge %0d: def=%0d m10=%0d dn=%0d want 0", k, out_def, out_m10, out_dn);
      end
    end
  endtask

  task automatic test_mod10;
    tick(1'b1);
    for (int k = 1; k <= 50; k++) begin
      tick(1'b0);
      compared++;
      if (out_m10 !== 4'(k % 10) || out_m10 >= 4'd10) begin
        mismatched++;
        $display("FAIL mod10 edge %0d: got %0d want %0d", k, out_m10, k % 10);
      end
    end
  endtask

  // rst pulses entirely between edges must not disturb the count.
  task automatic test_glitch;
    logic [3:0] held;
    for (int g = 0; g < 5; g++) begin
      tick(1'b0);
      held = out_def;
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      #2;
      compared++;
      if (out_def !== held || out_def !== 4'(m_def)) begin
        mismatched++;
        $display("FAIL glitch_between_edges %0d: got %0d want %0d", g, out_def, m_def);
      end
      tick(1'b0);
      compared++;
      if (out_def !== 4'(m_def) || out_m10 !== 4'(m_m10) || out_dn !== 4'(m_dn)) begin
        mismatched++;
        $display("FAIL glitch_next_edge %0d: def=%0d/%0d m10=%0d/%0d dn=%0d/%0d",
                 g, out_def, m_def, out_m10, m_m10, out_dn, m_dn);
      end
    end
  endtask

  task automatic test_random;
    bit r;
    for (int k = 0; k < 300; k++) begin
      r = ($urandom_range(7) == 0);
      tick(r);
      compared++;
      if (out_def !== 4'(m_def) || out_m10 !== 4'(m_m10) || out_dn !== 4'(m_dn)) begin
        mismatched++;
        $display("FAIL random edge %0d rst=%0d: def=%0d/%0d m10=%0d/%0d dn=%0d/%0d",
                 k, r, out_def, m_def, out_m10, m_m10, out_dn, m_dn);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_sequence();
    test_down();
    test_mid_reset();
    test_reset_held();
    test_mod10();
    test_glitch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
